submod_seq: RTL and testbench

Multi-cycle modular subtractor over the BLS12-381 base field: computes out = (inA − inB) mod p, p = `BLS381_CHAR`. It is the inverse operation of the single-cycle modular adder and sits beside it in the field-arithmetic datapath. It trades latency for area by processing the operands limb-serially behind a valid/ready handshake. Operands must be reduced (0 ≤ inA, inB < p); the output is always reduced.

---
 rtl/submod_seq.sv | 158 +++++++++++++++
 tb/tb_submod_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/submod_seq.sv
// submod_seq -- limb-serial modular subtractor over the BLS12-381 base field.
//
// Computes out = (inA - inB) mod p with p = BLS381_CHAR. Operands are taken
// one pair at a time behind a valid/ready handshake. One LIMB-wide slice is
// processed per cycle, so a result is ready NLIMB cycles after acceptance.
// Both operands must already be reduced (< p). The result is always reduced.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block idle and able to accept an operand pair
//   inA, inB   minuend / subtrahend, WORD bits, reduced
//   out_valid  result valid; held until out_ready
//   out_ready  consumer accepts the result
//   out        (inA - inB) mod p, WORD bits

`ifndef WORD_SIZE
`define WORD_SIZE 381
`endif

`ifndef BLS381_CHAR
`define BLS381_CHAR 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab
`endif

module submod_seq #(
  parameter int WORD  = `WORD_SIZE,
  parameter int LIMB  = 64,
  parameter int NLIMB = (WORD + LIMB - 1) / LIMB
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] inA,
  input  logic [WORD-1:0] inB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out
);

  localparam int PW = NLIMB * LIMB;
  localparam int CW = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CW-1:0] LAST_LIMB = CW'(NLIMB - 1);
  localparam logic [PW-1:0] P_PAD = PW'(`BLS381_CHAR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   a_reg, b_reg;
  logic [PW-1:0]   org_reg, alt_reg;
  logic [CW-1:0]   cnt_reg;
  logic            c0_reg, c1_reg;
  logic [WORD-1:0] out_reg;
  logic            out_valid_reg;

  // Modulus split into limbs. It is a constant, so selecting by cnt avoids
  // keeping a third shift register.
  logic [LIMB-1:0] p_limb [NLIMB];
  for (genvar gi = 0; gi < NLIMB; gi++) begin : g_p_limb
    assign p_limb[gi] = P_PAD[gi*LIMB +: LIMB];
  end

  // Per-limb datapath. Chain 0 forms A - B as A + ~B + 1 (c0 starts at 1).
  // Chain 1 adds p to that slice so that A - B + p is available whenever
  // the final borrow says A < B.
  logic [LIMB-1:0] a_limb, b_limb, org_limb, alt_limb;
  logic            c0_next, c1_next;
  logic [PW-1:0]   org_shift, alt_shift;

  always_comb begin
    a_limb = a_reg[LIMB-1:0];
    b_limb = b_reg[LIMB-1:0];
    {c0_next, org_limb} = {1'b0, a_limb} + {1'b0, ~b_limb} + {{LIMB{1'b0}}, c0_reg};
    {c1_next, alt_limb} = {1'b0, org_limb} + {1'b0, p_limb[cnt_reg]} + {{LIMB{1'b0}}, c1_reg};
    // Results enter at the top and move down, so after NLIMB steps limb 0
    // sits at the bottom.
    org_shift = (org_reg >> LIMB) | (PW'(org_limb) << (PW - LIMB));
    alt_shift = (alt_reg >> LIMB) | (PW'(alt_limb) << (PW - LIMB));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)              state_next = RUN;
      RUN:     if (cnt_reg == LAST_LIMB)  state_next = DONE;
      DONE:    if (out_ready)             state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  // Operand shifters, carry chains, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      org_reg       <= '0;
      alt_reg       <= '0;
      cnt_reg       <= '0;
      c0_reg        <= 1'b0;
      c1_reg        <= 1'b0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= PW'(inA);
            b_reg   <= PW'(inB);
            cnt_reg <= '0;
            c0_reg  <= 1'b1;
            c1_reg  <= 1'b0;
          end
        end
        RUN: begin
          a_reg   <= a_reg >> LIMB;
          b_reg   <= b_reg >> LIMB;
          org_reg <= org_shift;
          alt_reg <= alt_shift;
          c0_reg  <= c0_next;
          c1_reg  <= c1_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_LIMB) begin
            // No carry out of the full-width A + ~B + 1 means A < B.
            // In that case the p-corrected chain is the reduced answer.
            out_reg       <= c0_next ? org_shift[WORD-1:0] : alt_shift[WORD-1:0];
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign out       = out_reg;

endmodule

// File: tb/tb_submod_seq.sv
// Testbench for submod_seq: directed vector table, back-pressure and
// mid-operation reset sequences, and a randomized handshake stream checked
// against a (A - B) mod p reference model.
module tb_submod_seq;

  localparam int W  = 381;
  localparam int NL = 6;
  localparam logic [W-1:0] P =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] inA       = '0;
  logic [W-1:0] inB       = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  submod_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inA       (inA),
    .inB       (inB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  typedef struct {
    string        nm;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs [8];
  logic [W-1:0] exp_q [$];

  // Reference model: plain modular subtraction on wide integers.
  function automatic logic [W-1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+1:0] r;
    if (a >= b) r = {2'b00, a} - {2'b00, b};
    else        r = {2'b00, a} + {2'b00, P} - {2'b00, b};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_reduced();
    logic [383:0] t;
    logic [W-1:0] x;
    int           sel;
    for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
    x = t[W-1:0];
    if (x >= P) x = x - P;  // x < 2^381 < 2p, one subtraction suffices
    sel = int'($urandom_range(0, 15));
    if (sel == 0) x = '0;
    if (sel == 1) x = P - 1;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      n_pass++;
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // One full operation with out_ready held high. Returns the result and the
  // number of edges from acceptance to out_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output int lat);
    inA = a; inB = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = out;
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] one;
    logic [W-1:0] r;
    logic [W-1:0] held;
    int           lat;
    int           w;
    logic         seen;

    one = 1;
    vecs[0] = '{nm: "5-3",           a: 5,             b: 3,                   exp: 2};
    vecs[1] = '{nm: "3-5",           a: 3,             b: 5,                   exp: P - 2};
    vecs[2] = '{nm: "0-(p-1)",       a: 0,             b: P - 1,               exp: 1};
    vecs[3] = '{nm: "(p-1)-0",       a: P - 1,         b: 0,                   exp: P - 1};
    vecs[4] = '{nm: "x-x",           a: 'h1234,        b: 'h1234,              exp: 0};
    vecs[5] = '{nm: "2^64-1",        a: one << 64,     b: 1,                   exp: (one << 64) - 1};
    vecs[6] = '{nm: "2^320-(2^320+1)", a: one << 320,  b: (one << 320) + 1,    exp: P - 1};
    vecs[7] = '{nm: "1-(p-1)",       a: 1,             b: P - 1,               exp: 2};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready",  W'(in_ready),  1);
    chk("reset out_valid", W'(out_valid), 0);
    chk("reset out",       out,           0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, r, lat);
      chk({"vec ", vecs[i].nm}, r, vecs[i].exp);
      chk({"lat ", vecs[i].nm}, W'(lat), NL);
    end

    // Back-pressure, with in_valid left high (and ignored) while busy.
    inA = 100; inB = 42; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    inA = 50; inB = 8;
    w = 0;
    while (!out_valid && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp latency", W'(w), NL);
    held = out;
    chk("bp result", held, 58);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp out stable",    out,            held);
      chk("bp out_valid held", W'(out_valid), 1);
      chk("bp in_ready low",  W'(in_ready),   0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp after hs out_valid", W'(out_valid), 0);
    chk("bp after hs in_ready",  W'(in_ready),  1);
    // in_valid was high through the handshake; it is taken now, in IDLE.
    @(posedge clk); #1;
    chk("bp next accepted", W'(in_ready), 0);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp next result", out, 42);
    @(posedge clk); #1;

    // Reset in the middle of RUN (cnt == 2).
    inA = 11; inB = 4; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", W'(out_valid), 0);
    chk("mid reset in_ready",  W'(in_ready),  1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    chk("no pulse after reset", W'(seen), 0);
    do_op(7, 9, r, lat);
    chk("after reset 7-9", r, P - 2);

    // Randomized stream with gaps on both sides.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fork
      begin : producer
        logic [W-1:0] a, b;
        int           gap, wt;
        logic         acc;
        for (int i = 0; i < 1000; i++) begin
          gap = int'($urandom_range(0, 2));
          repeat (gap) begin @(posedge clk); #1; end
          a = rand_reduced();
          b = rand_reduced();
          inA = a; inB = b; in_valid = 1'b1;
          acc = 1'b0;
          wt  = 0;
          while (!acc && wt < 200) begin
            acc = in_ready;
            @(posedge clk); #1;
            wt++;
          end
          in_valid = 1'b0;
          if (!acc) begin
            chk("stream accept", W'(acc), 1);
            break;
          end
          exp_q.push_back(ref_sub(a, b));
        end
      end
      begin : consumer
        int got, cyc;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 60000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() > 0) chk($sformatf("stream #%0d", got), out, exp_q.pop_front());
            else                  chk("stream queue", W'(exp_q.size()), 1);
            got++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b1;
        chk("stream count", W'(got), 1000);
      end
    join
    chk("stream leftovers", W'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
